crack_multi: RTL and testbench

- Parametrised successor to the single-engine ARC4 key cracker.
- Dispatches the key space across NUM_LANES independent decrypt/check lanes, with interleaved assignment: lane i tests keys i, i+N, i+2N, ...
- Collects lane results; first match wins and aborts the other lanes.
- Sits between the top-level en/rdy control and the lane instances. Lanes own their own S/CT memories.

---
 rtl/crack_pkg.sv | 24 ++
 rtl/crack_lane_slot.sv | 55 +++++
 rtl/crack_multi.sv | 131 +++++++++++++
 tb/tb_crack_multi.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types and helpers for the multi-lane ARC4 key cracker.
package crack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam int KEY_W_DEF = 24;
  localparam int MAX_LANES = 16;

  function automatic int lane_lsb(input int lane, input int key_w);
    return lane * key_w;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/crack_lane_slot.sv
// Per-lane dispatcher: walks keys LANE_IDX, LANE_IDX+N, ... and tracks lane occupancy.
module crack_lane_slot
  import crack_pkg::*;
#(
  parameter int              NUM_LANES = 2,
  parameter int              KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W:0]  KEY_MAX   = {1'b0, {KEY_W{1'b1}}},
  parameter int              LANE_IDX  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             issue_en,
  input  logic             abort,
  input  logic             lane_rdy,
  input  logic             lane_done,
  output logic             lane_start,
  output logic [KEY_W-1:0] lane_key,
  output logic             busy,
  output logic             exhausted
);

  localparam logic [KEY_W:0] FIRST_KEY = (KEY_W+1)'(LANE_IDX);
  localparam logic [KEY_W:0] STRIDE    = (KEY_W+1)'(NUM_LANES);

  // One extra bit so stepping past KEY_MAX never wraps back into range.
  logic [KEY_W:0] next_key;

  assign exhausted = next_key > KEY_MAX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_key   <= FIRST_KEY;
      lane_key   <= '0;
      lane_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      lane_start <= 1'b0;
      if (load) begin
        next_key <= FIRST_KEY;
        busy     <= 1'b0;
      end else if (abort) begin
        busy <= 1'b0;
      end else if (issue_en && !busy && lane_rdy && !exhausted) begin
        lane_start <= 1'b1;
        lane_key   <= next_key[KEY_W-1:0];
        busy       <= 1'b1;
        next_key   <= next_key + STRIDE;
      end else if (busy && lane_done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/crack_multi.sv
// Multi-lane key-search controller; optional keys_tested counter under CRACK_PROGRESS_EN.
//   state | meaning
//   IDLE  | rdy=1, results held, waiting for en
//   RUN   | issuing interleaved keys to lanes, watching for a match or exhaustion
//   ABORT | one-cycle lane_abort broadcast after a match, then back to IDLE
module crack_multi
  import crack_pkg::*;
#(
  parameter int              NUM_LANES = 2,
  parameter int              KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W:0]  KEY_MAX   = {1'b0, {KEY_W{1'b1}}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  output logic                       rdy,
  output logic [KEY_W-1:0]           key,
  output logic                       key_valid,
  output logic [NUM_LANES-1:0]       lane_start,
  output logic [NUM_LANES*KEY_W-1:0] lane_key,
  output logic [NUM_LANES-1:0]       lane_abort,
  input  logic [NUM_LANES-1:0]       lane_rdy,
  input  logic [NUM_LANES-1:0]       lane_done,
  input  logic [NUM_LANES-1:0]       lane_found
`ifdef CRACK_PROGRESS_EN
  ,
  output logic [KEY_W:0]             keys_tested
`endif
);

  state_t               state, state_nxt;
  logic                 load, issue_en, abort_all, search_done;
  logic [NUM_LANES-1:0] busy, exhausted, match;
  logic [KEY_W-1:0]     match_key;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    crack_lane_slot #(
      .NUM_LANES (NUM_LANES),
      .KEY_W     (KEY_W),
      .KEY_MAX   (KEY_MAX),
      .LANE_IDX  (g)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .issue_en   (issue_en),
      .abort      (abort_all),
      .lane_rdy   (lane_rdy[g]),
      .lane_done  (lane_done[g]),
      .lane_start (lane_start[g]),
      .lane_key   (lane_key[lane_lsb(g, KEY_W) +: KEY_W]),
      .busy       (busy[g]),
      .exhausted  (exhausted[g])
    );
  end

  assign match       = lane_done & lane_found & busy;
  assign search_done = (&exhausted) && !(|busy) && !(|lane_done);
  assign lane_abort  = {NUM_LANES{abort_all}};

  // Walk high to low so the lowest matching lane is the last, winning assignment.
  always_comb begin
    match_key = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (match[i]) match_key = lane_key[i*KEY_W +: KEY_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    issue_en  = 1'b0;
    abort_all = 1'b0;
    rdy       = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // A match freezes issue so nothing starts in the abort cycle.
        if (|match) begin
          state_nxt = ABORT;
        end else begin
          issue_en = 1'b1;
          if (search_done) state_nxt = IDLE;
        end
      end
      ABORT: begin
        abort_all = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key       <= '0;
      key_valid <= 1'b0;
    end else if (load) begin
      key       <= '0;
      key_valid <= 1'b0;
    end else if (state == RUN && |match) begin
      key <= match_key;
    end else if (state == ABORT) begin
      key_valid <= 1'b1;
    end
  end

`ifdef CRACK_PROGRESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_tested <= '0;
    end else if (load) begin
      keys_tested <= '0;
    end else if (state == RUN) begin
      keys_tested <= keys_tested + (KEY_W+1)'(popcount16(16'(lane_done)));
    end
  end
`endif

endmodule

// File: tb/tb_crack_multi.sv
// Bench for crack_multi: behavioural lane responders plus search-outcome checks.
module tb_crack_multi;

  localparam int             NL   = 4;
  localparam int             KW   = 8;
  localparam int             KM   = 13;
  localparam logic [KW:0]    KMAX = 9'd13;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             rdy;
  logic [KW-1:0]    key;
  logic             key_valid;
  logic [NL-1:0]    lane_start;
  logic [NL*KW-1:0] lane_key;
  logic [NL-1:0]    lane_abort;
  logic [NL-1:0]    lane_rdy;
  logic [NL-1:0]    lane_done = '0;
  logic [NL-1:0]    lane_found = '0;
`ifdef CRACK_PROGRESS_EN
  logic [KW:0]      keys_tested;
`endif

  always #5 clk = ~clk;

  crack_multi #(.NUM_LANES(NL), .KEY_W(KW), .KEY_MAX(KMAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rdy        (rdy),
    .key        (key),
    .key_valid  (key_valid),
    .lane_start (lane_start),
    .lane_key   (lane_key),
    .lane_abort (lane_abort),
    .lane_rdy   (lane_rdy),
    .lane_done  (lane_done),
    .lane_found (lane_found)
`ifdef CRACK_PROGRESS_EN
    ,
    .keys_tested(keys_tested)
`endif
  );

  // Lane model state
  int            lat [NL];
  int            cnt [NL];
  int            lkey [NL];
  int            first_key [NL];
  logic [NL-1:0] lbusy = '0;
  logic [NL-1:0] hold = '0;
  logic [15:0]   found_set = '0;
  bit            noise_en = 1'b0;

  // Issue log
  int issue_cnt [256];
  int bad_lane, over, hold_starts, other_starts, abort_cycles, max_issued;
  int k;

  int tests = 0;
  int fails = 0;

  assign lane_rdy = ~lbusy & ~hold;

  typedef struct {
    logic [15:0] found;
    logic [31:0] lat;
    logic [3:0]  hold_mask;
    int          hold_cyc;
    bit          en_noise;
    bit          noise;
    bit          exp_valid;
    int          exp_key;
    int          exp_max;
    bit          chk_prog;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    for (int j = 0; j < 256; j++) issue_cnt[j] = 0;
    for (int j = 0; j < NL; j++) first_key[j] = -1;
    bad_lane = 0; over = 0; hold_starts = 0; other_starts = 0;
    abort_cycles = 0; max_issued = -1;
  endtask

  // Lanes react on the falling edge so the DUT sees stable inputs at the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      lbusy      = '0;
      lane_done  = '0;
      lane_found = '0;
    end else begin
      lane_done  = '0;
      lane_found = '0;
      if (|lane_abort) begin
        abort_cycles++;
        lbusy = '0;
      end else begin
        for (int i = 0; i < NL; i++) begin
          if (lbusy[i]) begin
            cnt[i]--;
            if (cnt[i] <= 0) begin
              lane_done[i]  = 1'b1;
              lane_found[i] = (lkey[i] < 16) ? found_set[lkey[i]] : 1'b0;
              lbusy[i]      = 1'b0;
            end
          end
          if (lane_start[i]) begin
            k = int'(lane_key[i*KW +: KW]);
            issue_cnt[k]++;
            if (k % NL != i) bad_lane++;
            if (k > KM) over++;
            if (k > max_issued) max_issued = k;
            if (first_key[i] < 0) first_key[i] = k;
            if (hold[i]) hold_starts++;
            if (hold != '0 && !hold[i]) other_starts++;
            lbusy[i] = 1'b1;
            cnt[i]   = lat[i];
            lkey[i]  = k;
          end else if (noise_en && !lbusy[i] && !lane_done[i] && $urandom_range(0, 7) == 0) begin
            lane_done[i]  = 1'b1;
            lane_found[i] = 1'b1;
          end
          if (noise_en && !lane_done[i]) lane_found[i] = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic run_search(input int budget, input bit en_noise, input int hold_cyc,
                            output bit timed_out);
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    check("rdy_low_after_en", rdy, 0);
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (rdy) begin
        timed_out = 1'b0;
        break;
      end
      if (c == hold_cyc) hold = '0;
      if (en_noise) en = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    en   = 1'b0;
    hold = '0;
  endtask

  task automatic do_search(input vec_t v);
    bit to;
    int dup, miss;
    found_set = v.found;
    for (int i = 0; i < NL; i++) lat[i] = int'(v.lat[i*8 +: 8]);
    clear_log();
    hold     = v.hold_mask;
    noise_en = v.noise;
    run_search(3000, v.en_noise, v.hold_cyc, to);
    noise_en = 1'b0;
    check("search_timeout", to, 0);
    check("key_valid", key_valid, v.exp_valid);
    check("key", key, v.exp_key);
    check("rdy_after", rdy, 1);
    check("abort_pulses", abort_cycles, v.exp_valid);
    dup = 0; miss = 0;
    for (int j = 0; j < 256; j++) if (issue_cnt[j] > 1) dup++;
    if (!v.exp_valid) begin
      for (int j = 0; j <= KM; j++) if (issue_cnt[j] != 1) miss++;
    end else if (issue_cnt[v.exp_key] != 1) begin
      miss++;
    end
    check("issue_dup", dup, 0);
    check("issue_coverage", miss, 0);
    check("issue_lane", bad_lane, 0);
    check("issue_range", over, 0);
    if (v.exp_max >= 0) check("max_issued", max_issued, v.exp_max);
    if (v.hold_mask != '0) begin
      check("hold_starts", hold_starts, 0);
      check("other_lanes_ran", other_starts > 0, 1);
    end
`ifdef CRACK_PROGRESS_EN
    if (v.chk_prog) check("keys_tested", keys_tested, KM + 1);
`endif
    repeat (2) @(negedge clk);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    //            found      lat (lane3..0)                       hold  cyc en_n noise val key max prog
    tbl[0] = '{16'h0200, {4{8'd20}},                       4'h0, 0,  0, 0, 1,  9, 11, 0};
    tbl[1] = '{16'h0000, {8'd2, 8'd7, 8'd5, 8'd3},         4'h0, 0,  0, 0, 0,  0, 13, 1};
    tbl[2] = '{16'h00A0, {4{8'd6}},                        4'h0, 0,  0, 0, 1,  5,  7, 0};
    tbl[3] = '{16'h0000, {4{8'd4}},                        4'h4, 50, 1, 0, 0,  0, 13, 1};
    tbl[4] = '{16'h2000, {8'd4, 8'd3, 8'd2, 8'd1},         4'h0, 0,  0, 0, 1, 13, 13, 0};
    tbl[5] = '{16'h0001, {4{8'd1}},                        4'h0, 0,  0, 0, 1,  0,  3, 0};
    tbl[6] = '{16'hC000, {4{8'd3}},                        4'h0, 0,  0, 0, 0,  0, 13, 1};

    clear_log();
    for (int i = 0; i < NL; i++) lat[i] = 1;
    repeat (2) @(negedge clk);
    check("reset_rdy", rdy, 1);
    check("reset_key_valid", key_valid, 0);
    check("reset_key", key, 0);
    check("reset_lane_key", lane_key, 0);
    check("reset_lane_start", lane_start, 0);
    check("reset_lane_abort", lane_abort, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rdy", rdy, 1);

    for (int t = 0; t < 7; t++) do_search(tbl[t]);

    // Reset in the middle of a long search
    found_set = '0;
    for (int i = 0; i < NL; i++) lat[i] = 40;
    clear_log();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (100) @(negedge clk);
    check("rdy_busy_pre_reset", rdy, 0);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("midrun_rdy", rdy, 1);
    check("midrun_key_valid", key_valid, 0);
    check("midrun_key", key, 0);
    check("midrun_lane_key", lane_key, 0);
    check("midrun_lane_start", lane_start, 0);
    check("midrun_lane_abort", lane_abort, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv = '{16'h0000, {4{8'd2}}, 4'h0, 0, 0, 0, 0, 0, 13, 1};
    do_search(rv);
    for (int i = 0; i < NL; i++) check($sformatf("restart_first_key%0d", i), first_key[i], i);

    // Randomised searches against the outcome model
    for (int r = 0; r < 20; r++) begin
      int tgt;
      tgt          = $urandom_range(0, 17);
      rv.found     = (tgt < 16) ? (16'h1 << tgt) : 16'h0;
      for (int i = 0; i < NL; i++) rv.lat[i*8 +: 8] = 8'($urandom_range(1, 8));
      rv.hold_mask = ($urandom_range(0, 1) == 1) ? (4'h1 << $urandom_range(0, NL - 1)) : 4'h0;
      rv.hold_cyc  = $urandom_range(5, 30);
      rv.en_noise  = 1'($urandom_range(0, 1));
      rv.noise     = 1'b1;
      rv.exp_valid = (tgt <= KM);
      rv.exp_key   = (tgt <= KM) ? tgt : 0;
      rv.exp_max   = -1;
      rv.chk_prog  = 1'b0;
      do_search(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
